// File: rtl/rx_pkg.sv
// rx_pkg: shared types and constants for the serial receive engine.
// State encoding, queue geometry and the size/burst clamp helpers.
package rx_pkg;

  localparam int MAX_BITS = 32;
  localparam int QDEPTH   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    STOP = 2'd2,
    ACK  = 2'd3
  } rx_state_t;

  // 0 or anything wider than the word register means a full 32-bit word
  function automatic logic [5:0] eff_size(
    input logic [7:0] s
  );
    if (s == 8'd0 || s > 8'd32) begin
      return 6'd32;
    end
    return s[5:0];
  endfunction

  // a zero-word frame still carries one word
  function automatic logic [7:0] eff_burst(
    input logic [7:0] b
  );
    if (b == 8'd0) begin
      return 8'd1;
    end
    return b;
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: small FIFO holding completed receive words.
// A pop frees a slot in the same cycle, so push+pop works when full.
module rx_word_fifo #(
  parameter int W     = rx_pkg::MAX_BITS,
  parameter int DEPTH = rx_pkg::QDEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // head word, forced to zero when nothing is queued
  assign dout = empty ? '0 : mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/receiver_core.sv
// receiver_core: start detect, MSB-first deserialiser, stop check, ack.
// Completed words go to a 2-entry queue drained by valid/ready.
module receiver_core #(
  parameter int MAX_BITS = rx_pkg::MAX_BITS,
  parameter int QDEPTH   = rx_pkg::QDEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sda_in,
  output logic                sda_out,
  output logic                sda_oe,
  input  logic [7:0]          size,
  input  logic [7:0]          burst,
  output logic [MAX_BITS-1:0] rxdata,
  output logic                rxvalid,
  input  logic                rxready,
  output logic                busy,
  output logic                frame_err,
  output logic                overrun
);

  import rx_pkg::*;

  rx_state_t           state;
  logic [5:0]          bit_cnt;
  logic [5:0]          bit_len;
  logic [7:0]          word_cnt;
  logic [MAX_BITS-1:0] shift;
  logic [MAX_BITS-1:0] word;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;

  // the word completes on the bit sampled while the counter reads 1
  assign word = {shift[MAX_BITS-2:0], sda_in};
  assign push = (state == RECV) && (bit_cnt == 6'd1);
  assign pop  = rxvalid && rxready;

  assign rxvalid = !empty;
  assign busy    = (state != IDLE);

  rx_word_fifo #(
    .W     (MAX_BITS),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .dout  (rxdata),
    .full  (full),
    .empty (empty)
  );

  // overrun pulse: a completed word found no free slot this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
    end
  end

  // frame FSM with counters, shift register and registered line outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_len   <= '0;
      word_cnt  <= '0;
      shift     <= '0;
      sda_oe    <= 1'b0;
      sda_out   <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      sda_oe    <= 1'b0;
      sda_out   <= 1'b1;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!sda_in) begin
            bit_len  <= eff_size(size);
            bit_cnt  <= eff_size(size);
            word_cnt <= eff_burst(burst);
            shift    <= '0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (bit_cnt == 6'd1) begin
            shift <= '0;
            if (word_cnt == 8'd1) begin
              state <= STOP;
            end else begin
              word_cnt <= word_cnt - 8'd1;
              bit_cnt  <= bit_len;
            end
          end else begin
            shift   <= word;
            bit_cnt <= bit_cnt - 6'd1;
          end
        end
        STOP: begin
          if (sda_in) begin
            sda_oe  <= 1'b1;
            sda_out <= 1'b0;
            state   <= ACK;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        ACK: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
